// File: rtl/const_vector_ctrl.sv
// Constant vector bank for DECODE: stream-loaded 8 x DATA_W entries, round-robin shared 4-lane read port.
// Optional write-once lock enabled by defining CONST_LOCK_EN (adds output locked).
module const_vector_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 4,
    parameter int unsigned BANKS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
`ifdef CONST_LOCK_EN
    output logic              locked,
`endif
    input  logic              req_a,
    input  logic              req_b,
    input  logic              pos_a,
    input  logic              pos_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rd_valid,
    output logic              rd_owner,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4
);

    localparam int unsigned ENTRIES = LANES * BANKS;
    localparam int unsigned CW      = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              last_b;
    logic [DATA_W-1:0] mem  [ENTRIES];
    logic [DATA_W-1:0] rd_q [LANES];
    logic              start_eff;
    logic              bank_sel;
    logic [CW-1:0]     rd_base;

`ifdef CONST_LOCK_EN
    logic lock_q;
    assign locked = lock_q;
    always_comb start_eff = ld_start & ~lock_q;
`else
    always_comb start_eff = ld_start;
`endif

    // A pending load start blocks arbitration in the same cycle.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst && state == IDLE && !start_eff) begin
            if (req_a && (!req_b || last_b))
                gnt_a = 1'b1;
            else if (req_b)
                gnt_b = 1'b1;
        end
    end

    always_comb begin
        bank_sel = gnt_b ? pos_b : pos_a;
        rd_base  = CW'(LANES * 32'(bank_sel));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_b   <= 1'b1;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            for (int unsigned i = 0; i < ENTRIES; i++)
                mem[i] <= '0;
            for (int unsigned i = 0; i < LANES; i++)
                rd_q[i] <= '0;
`ifdef CONST_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            rd_valid <= gnt_a | gnt_b;
            if (gnt_a || gnt_b) begin
                rd_owner <= gnt_b;
                last_b   <= gnt_b;
                for (int unsigned i = 0; i < LANES; i++)
                    rd_q[i] <= mem[rd_base + CW'(i)];
            end
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_eff) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid && ld_ready) begin
                        mem[cnt] <= ld_data;
                        if (cnt == CW'(ENTRIES - 1)) begin
                            cnt      <= '0;
                            state    <= DONE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
`ifdef CONST_LOCK_EN
                            lock_q   <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign out1 = rd_q[0];
    assign out2 = rd_q[1];
    assign out3 = rd_q[2];
    assign out4 = rd_q[3];

endmodule

// File: tb/tb_const_vector_ctrl.sv
// Scoreboard bench for const_vector_ctrl: behavioural model pushes expected reads, monitor pops on rd_valid.
module tb_const_vector_ctrl;

    typedef logic [31:0] words_t [8];
    typedef struct packed {
        logic         owner;
        logic [127:0] vec;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start, ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready, ld_done, busy;
    logic        req_a, req_b, pos_a, pos_b;
    logic        gnt_a, gnt_b, rd_valid, rd_owner;
    logic [31:0] out1, out2, out3, out4;
`ifdef CONST_LOCK_EN
    logic        locked;
`endif

    const_vector_ctrl #(.DATA_W(32), .LANES(4), .BANKS(2)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy),
`ifdef CONST_LOCK_EN
        .locked(locked),
`endif
        .req_a(req_a), .req_b(req_b), .pos_a(pos_a), .pos_b(pos_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rd_valid(rd_valid), .rd_owner(rd_owner),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 = idle, 1 = loading, 2 = done pulse.
    int          mphase = 0;
    int          mcnt   = 0;
    logic [31:0] mmem [8];
    bit          mlast_b = 1'b1;
    bit          mlocked = 1'b0;
    bit          mrdv    = 1'b0;
    rd_t         sbq [$];

    always @(negedge clk) begin
        bit ega, egb, start;
        int base;
        if (rst) begin
            mphase = 0; mcnt = 0; mlast_b = 1'b1; mlocked = 1'b0; mrdv = 1'b0;
            for (int i = 0; i < 8; i++) mmem[i] = '0;
            sbq.delete();
            check("reset", {gnt_a, gnt_b, ld_ready, ld_done, busy, rd_valid, rd_owner,
                            out1, out2, out3, out4}, '0);
        end else begin
            start = ld_start && !mlocked;
            ega = 1'b0; egb = 1'b0;
            if (mphase == 0 && !start) begin
                if (req_a && (!req_b || mlast_b)) ega = 1'b1;
                else if (req_b) egb = 1'b1;
            end
            check("ctrl", {gnt_a, gnt_b, ld_ready, ld_done, busy, rd_valid},
                  {ega, egb, mphase == 1, mphase == 2, mphase != 0, mrdv});
`ifdef CONST_LOCK_EN
            check("locked", locked, mlocked);
`endif
            if (ega || egb) begin
                base = 4 * ((egb ? pos_b : pos_a) ? 1 : 0);
                sbq.push_back('{owner: egb,
                                vec: {mmem[base+3], mmem[base+2], mmem[base+1], mmem[base]}});
                mlast_b = egb;
            end
            mrdv = ega || egb;
            case (mphase)
                0: if (start) begin mphase = 1; mcnt = 0; end
                1: if (ld_valid) begin
                       mmem[mcnt] = ld_data;
                       mcnt++;
                       if (mcnt == 8) begin
                           mphase = 2; mcnt = 0;
`ifdef CONST_LOCK_EN
                           mlocked = 1'b1;
`endif
                       end
                   end
                default: mphase = 0;
            endcase
        end
    end

    // Monitor: pops the oldest expected vector whenever the DUT presents one.
    rd_t held = '0;
    always @(negedge clk) begin
        rd_t e;
        if (rst) begin
            held = '0;
        end else if (rd_valid) begin
            if (sbq.size() == 0) begin
                check("rd_unexpected", rd_valid, 1'b0);
            end else begin
                e = sbq.pop_front();
                check("rd_data", {rd_owner, out4, out3, out2, out1}, e);
                held = e;
            end
        end else begin
            check("rd_hold", {rd_owner, out4, out3, out2, out1}, held);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        req_a = 1'b0; req_b = 1'b0; pos_a = 1'b0; pos_b = 1'b0;
    endtask

    // mode: 0 = valid held, 1 = valid toggling, 2 = random valid.
    task automatic do_load(input words_t w, input int mode, input int stop_after);
        int  i   = 0;
        int  cyc = 0;
        bit  tog = 1'b1;
        bit  acc;
        ld_start = 1'b1; ld_valid = 1'b0;
        step();
        ld_start = 1'b0;
        while (i < stop_after && cyc < 100) begin
            ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog      = !tog;
            ld_data  = w[i];
            @(negedge clk);
            acc = ld_valid && ld_ready;
            step();
            if (acc) i++;
            cyc++;
        end
        ld_valid = 1'b0;
        ld_data  = $urandom;
        check("load_words", i, stop_after);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 20) begin step(); cyc++; end
        check("done_wait", busy, 1'b0);
    endtask

    task automatic read(input bit ra, input bit pa, input bit rb, input bit pb, input int n);
        req_a = ra; pos_a = pa; req_b = rb; pos_b = pb;
        repeat (n) step();
        req_a = 1'b0; req_b = 1'b0;
        step();
    endtask

    words_t base_w, rnd_w;

    initial begin
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) base_w[i] = 32'h10 + 32'(i);
        repeat (2) step();
        rst = 1'b0;
        step();

        do_load(base_w, 0, 8);
        wait_idle();
        read(1'b1, 1'b1, 1'b0, 1'b0, 1);
        read(1'b1, 1'b0, 1'b1, 1'b1, 4);

`ifdef CONST_LOCK_EN
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hAA;
        repeat (10) step();
        ld_start = 1'b0; ld_valid = 1'b0;
        step();
        read(1'b1, 1'b0, 1'b1, 1'b1, 2);
`else
        req_b = 1'b1; pos_b = 1'($urandom_range(0, 1));
        do_load(base_w, 1, 8);
        wait_idle();
        step();
        req_b = 1'b0;
        step();
        read(1'b1, 1'b0, 1'b1, 1'b1, 2);
`endif

        for (int c = 0; c < 300; c++) begin
`ifndef CONST_LOCK_EN
            if (c % 100 == 50) begin
                req_a = 1'b0; req_b = 1'b0;
                for (int i = 0; i < 8; i++) rnd_w[i] = $urandom;
                do_load(rnd_w, 2, 8);
                wait_idle();
            end
`endif
            req_a = 1'($urandom_range(0, 1)); pos_a = 1'($urandom_range(0, 1));
            req_b = 1'($urandom_range(0, 1)); pos_b = 1'($urandom_range(0, 1));
            step();
        end
        req_a = 1'b0; req_b = 1'b0;
        step();

        for (int i = 0; i < 8; i++) rnd_w[i] = $urandom;
        do_load(rnd_w, 0, 3);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        read(1'b1, 1'b0, 1'b0, 1'b0, 1);
        read(1'b0, 1'b0, 1'b1, 1'b1, 1);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
